// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared types and constants for the WM8731 configuration
// sequencer. Holds the FSM state enum, the launch decision enum, the
// power-up register table and the I2C word packing helper.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT_ISSUE = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_USER_ISSUE = 3'd3,
    ST_USER_WAIT  = 3'd4,
    ST_GAP        = 3'd5
  } state_t;

  // What to start when the sequencer is free (IDLE or end of GAP).
  typedef enum logic [1:0] {
    L_NONE      = 2'd0,
    L_INIT_NEW  = 2'd1,
    L_INIT_CONT = 2'd2,
    L_USER      = 2'd3
  } launch_t;

  localparam int INIT_LEN = 11;

  // Power-up table, {reg[6:0], data[8:0]}. Reset first, activate last.
  localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
    16'h1E00,  // R15 = 0x000 reset
    16'h0017,  // R0  = 0x017
    16'h0217,  // R1  = 0x017
    16'h0479,  // R2  = 0x079
    16'h0679,  // R3  = 0x079
    16'h0812,  // R4  = 0x012
    16'h0A00,  // R5  = 0x000
    16'h0C00,  // R6  = 0x000
    16'h0E02,  // R7  = 0x002
    16'h1000,  // R8  = 0x000
    16'h1201   // R9  = 0x001 active
  };

  function automatic logic [23:0] pack_word(input logic [7:0] dev,
                                            input logic [6:0] reg_addr,
                                            input logic [8:0] reg_data);
    return {dev, reg_addr, reg_data};
  endfunction

endpackage

// File: rtl/codec_cfg_seq_rom.sv
// codec_cfg_rom: combinational lookup of the power-up table.
// Ports:
//   i_ptr  [3:0]  table index
//   o_word [15:0] {reg, data}; zero beyond the end of the table
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  i_ptr,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    if (i_ptr < 4'(INIT_LEN)) o_word = INIT_TABLE[i_ptr];
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: sequences every WM8731 register write through the single
// I2C master. Runs the power-up table on start_init, then serves single
// Avalon register writes. NACKed transfers are retried up to MAX_RETRY
// extra times; a bus-free gap of GAP_CYCLES follows every transaction.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start_init                   pulse: run the init table
//   av_req/av_reg_addr/av_reg_data  user write request (held until av_ack)
//   av_ack, av_err               user write finished / failed
//   busy, init_done, err         status (init_done and err sticky)
//   i2c_go, i2c_data             start pulse and 24-bit word to the master
//   i2c_done, i2c_nack           completion and NACK flag from the master
//
// state      | meaning
// IDLE       | nothing in flight, waiting for start_init or av_req
// INIT_ISSUE | i2c_go high with the current table word
// INIT_WAIT  | waiting for the master to finish a table word
// USER_ISSUE | i2c_go high with the captured user word
// USER_WAIT  | waiting for the master to finish a user word
// GAP        | bus free time before the next transaction
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         GAP_CYCLES = 16,
  parameter int         MAX_RETRY  = 3,
  parameter logic [7:0] DEV_ADDR   = 8'h34
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_init,
  input  logic        av_req,
  input  logic [6:0]  av_reg_addr,
  input  logic [8:0]  av_reg_data,
  output logic        av_ack,
  output logic        av_err,
  output logic        busy,
  output logic        init_done,
  output logic        err,
  output logic        i2c_go,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_nack
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [3:0]    PTR_LAST  = 4'(INIT_LEN - 1);

  state_t          r_state;
  logic [3:0]      r_ptr;
  logic [1:0]      r_retry;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_pend_init;
  logic            r_init_run;    // table in progress (incl. retries and gaps)
  logic            r_user_retry;  // user word NACKed, re-issue after the gap
  logic            r_go;
  logic [23:0]     r_data;
  logic            r_ack;
  logic            r_av_err;
  logic            r_init_done;
  logic            r_err;

  launch_t         w_launch;
  logic            w_gap_end;
  logic [3:0]      w_rom_ptr;
  logic [15:0]     w_rom_word;
  logic [23:0]     w_init_word;
  logic [23:0]     w_user_word;

  // GAP hands off straight to the next transfer, so done-to-go latency is
  // GAP_CYCLES+1 whether the next word is init, a retry, or a user write.
  always_comb begin
    w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == '0);
    w_launch  = L_NONE;
    if ((r_state == ST_IDLE) || w_gap_end) begin
      if (r_init_run)                     w_launch = L_INIT_CONT;
      else if (r_user_retry)              w_launch = L_USER;
      else if (r_pend_init || start_init) w_launch = L_INIT_NEW;
      else if (av_req)                    w_launch = L_USER;
    end
    w_rom_ptr = (w_launch == L_INIT_NEW) ? 4'd0 : r_ptr;
  end

  codec_cfg_rom u_rom (
    .i_ptr  (w_rom_ptr),
    .o_word (w_rom_word)
  );

  assign w_init_word = pack_word(DEV_ADDR, w_rom_word[15:9], w_rom_word[8:0]);
  assign w_user_word = pack_word(DEV_ADDR, av_reg_addr, av_reg_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 4'd0;
      r_retry      <= 2'd0;
      r_gap_cnt    <= '0;
      r_pend_init  <= 1'b0;
      r_init_run   <= 1'b0;
      r_user_retry <= 1'b0;
      r_go         <= 1'b0;
      r_data       <= 24'h0;
      r_ack        <= 1'b0;
      r_av_err     <= 1'b0;
      r_init_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_go     <= 1'b0;
      r_ack    <= 1'b0;
      r_av_err <= 1'b0;

      // A restart request during a running table is dropped.
      if (start_init && (r_state != ST_IDLE) && !r_init_run) r_pend_init <= 1'b1;

      case (r_state)
        ST_IDLE: ;
        ST_INIT_ISSUE: r_state <= ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (i2c_done) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LOAD;
            if (!i2c_nack) begin
              r_retry <= 2'd0;
              r_ptr   <= r_ptr + 4'd1;
              if (r_ptr == PTR_LAST) begin
                r_init_done <= 1'b1;
                r_init_run  <= 1'b0;
              end
            end else if (r_retry != RETRY_MAX) begin
              r_retry <= r_retry + 2'd1;
            end else begin
              r_err      <= 1'b1;
              r_init_run <= 1'b0;
              r_retry    <= 2'd0;
            end
          end
        end
        ST_USER_ISSUE: r_state <= ST_USER_WAIT;
        ST_USER_WAIT: begin
          if (i2c_done) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LOAD;
            if (!i2c_nack || (r_retry == RETRY_MAX)) begin
              r_ack        <= 1'b1;
              r_av_err     <= i2c_nack;
              r_retry      <= 2'd0;
              r_user_retry <= 1'b0;
            end else begin
              r_retry      <= r_retry + 2'd1;
              r_user_retry <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GW'(1);
          else                 r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      case (w_launch)
        L_INIT_NEW: begin
          r_ptr       <= 4'd0;
          r_retry     <= 2'd0;
          r_err       <= 1'b0;
          r_init_done <= 1'b0;
          r_init_run  <= 1'b1;
          r_pend_init <= 1'b0;
          r_state     <= ST_INIT_ISSUE;
          r_go        <= 1'b1;
          r_data      <= w_init_word;
        end
        L_INIT_CONT: begin
          r_state <= ST_INIT_ISSUE;
          r_go    <= 1'b1;
          r_data  <= w_init_word;
        end
        L_USER: begin
          r_state <= ST_USER_ISSUE;
          r_go    <= 1'b1;
          r_data  <= w_user_word;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign i2c_go    = r_go;
  assign i2c_data  = r_data;
  assign av_ack    = r_ack;
  assign av_err    = r_av_err;
  assign init_done = r_init_done;
  assign err       = r_err;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Testbench for codec_cfg_seq: an I2C master model with random latency and
// scripted NACKs, plus an expected-transaction queue built from the register
// table and retry rules.
module tb_codec_cfg_seq;

  localparam int GAP  = 16;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_init = 1'b0;
  logic        av_req = 1'b0;
  logic [6:0]  av_reg_addr = 7'h0;
  logic [8:0]  av_reg_data = 9'h0;
  logic        av_ack, av_err, busy, init_done, err, i2c_go;
  logic [23:0] i2c_data;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;

  codec_cfg_seq #(.GAP_CYCLES(GAP), .MAX_RETRY(MAXR), .DEV_ADDR(8'h34)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_init  (start_init),
    .av_req      (av_req),
    .av_reg_addr (av_reg_addr),
    .av_reg_data (av_reg_data),
    .av_ack      (av_ack),
    .av_err      (av_err),
    .busy        (busy),
    .init_done   (init_done),
    .err         (err),
    .i2c_go      (i2c_go),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 untimed, 1 GAP+1 after previous done, 2 one cycle after request
  typedef struct {
    logic [23:0] word;
    int          kind;
  } exp_t;

  exp_t exp_q[$];
  logic nack_q[$];
  logic err_q[$];
  exp_t mon_e;

  int n_vec = 0, n_err = 0;
  int n_go = 0, n_pushed = 0, n_flushed = 0;
  int last_done_cyc = 0, ref_cyc = 0, lat_cnt = 0;
  logic cur_nack = 1'b0;

  int tbl_reg[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int tbl_dat[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h002, 'h000, 'h001};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_word(input int r, input int d);
    return 24'(('h34 << 16) + (r << 9) + d);
  endfunction

  task automatic expect_go(input logic [23:0] w, input int kind, input logic nack);
    exp_t e;
    e.word = w;
    e.kind = kind;
    exp_q.push_back(e);
    nack_q.push_back(nack);
    n_pushed++;
  endtask

  // Entry i is NACKed nacks[i] times; more than MAXR NACKs abandons the table.
  task automatic plan_init(input int nacks[11], input int first_kind, output logic ok);
    bit first = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      int tries = (nacks[i] > MAXR) ? MAXR + 1 : nacks[i] + 1;
      for (int t = 0; t < tries; t++) begin
        expect_go(model_word(tbl_reg[i], tbl_dat[i]), first ? first_kind : 1, t < nacks[i]);
        first = 1'b0;
      end
      if (nacks[i] > MAXR) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic plan_user(input int r, input int d, input int nacks, input int first_kind);
    int tries = (nacks > MAXR) ? MAXR + 1 : nacks + 1;
    for (int t = 0; t < tries; t++) expect_go(model_word(r, d), (t == 0) ? first_kind : 1, t < nacks);
    err_q.push_back(nacks > MAXR);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || exp_q.size() != 0 || err_q.size() != 0) && k < budget);
    check_val({tag, "_timeout"}, int'(k < budget), 1);
  endtask

  task automatic wait_go(input int target, input int budget, input string tag);
    int k = 0;
    while (n_go < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_timeout"}, int'(k < budget), 1);
  endtask

  task automatic pulse_start();
    ref_cyc = cyc;
    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
  endtask

  task automatic request_user(input int r, input int d);
    ref_cyc = cyc;
    av_reg_addr = 7'(r);
    av_reg_data = 9'(d);
    av_req = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_go"},   int'(i2c_go), 0);
    check_val({tag, "_data"}, int'(i2c_data), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(init_done), 0);
    check_val({tag, "_err"},  int'(err), 0);
    check_val({tag, "_ack"},  int'(av_ack), 0);
    check_val({tag, "_averr"}, int'(av_err), 0);
  endtask

  // I2C master model and Avalon requester, active on the falling edge.
  initial forever begin
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!reset_n) begin
      lat_cnt = 0;
    end else begin
      if (i2c_go) begin
        n_go++;
        check_val("go_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_val("go_word", int'(i2c_data), int'(mon_e.word));
          if (mon_e.kind == 1)      check_val("gap_lat", cyc - last_done_cyc, GAP + 1);
          else if (mon_e.kind == 2) check_val("req_lat", cyc - ref_cyc, 1);
        end
        cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        lat_cnt = $urandom_range(2, 6);
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          i2c_done = 1'b1;
          i2c_nack = cur_nack;
          last_done_cyc = cyc;
        end
      end
      if (av_ack) begin
        check_val("ack_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) begin
          check_val("ack_err", int'(av_err), int'(err_q.pop_front()));
          check_val("ack_lat", cyc - last_done_cyc, 1);
        end
        av_req = 1'b0;
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   nk[11];
    int   r, d, n, base;
    logic ok;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean init run.
    foreach (nk[i]) nk[i] = 0;
    plan_init(nk, 2, ok);
    pulse_start();
    wait_idle(4000, "init_clean");
    check_val("init_clean_done", int'(init_done), int'(ok));
    check_val("init_clean_err", int'(err), 0);

    // Random NACKs, entry 3 NACKed twice.
    foreach (nk[i]) nk[i] = $urandom_range(0, 2);
    nk[3] = 2;
    plan_init(nk, 2, ok);
    pulse_start();
    wait_idle(4000, "init_nack");
    check_val("init_nack_done", int'(init_done), int'(ok));
    check_val("init_nack_err", int'(err), 0);

    // Retry exhaustion: entry 0 first, then a random entry.
    for (int s = 0; s < 2; s++) begin
      int e = (s == 0) ? 0 : $urandom_range(1, 10);
      foreach (nk[i]) nk[i] = (i < e) ? $urandom_range(0, 1) : 0;
      nk[e] = MAXR + 1;
      plan_init(nk, 2, ok);
      pulse_start();
      wait_idle(4000, "init_abort");
      check_val("abort_err", int'(err), int'(!ok));
      check_val("abort_done", int'(init_done), 0);
      check_val("abort_idle", int'(busy), 0);
    end

    // Restart after an abort clears err.
    foreach (nk[i]) nk[i] = 0;
    plan_init(nk, 2, ok);
    pulse_start();
    check_val("restart_err_clr", int'(err), 0);
    wait_idle(4000, "init_restart");
    check_val("restart_done", int'(init_done), 1);

    // User writes: first directed, second exhausts retries, rest random.
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 'h04 : $urandom_range(0, 127);
      d = (i == 0) ? 'h010 : $urandom_range(0, 511);
      n = (i == 0) ? 0 : (i == 1) ? MAXR + 1 : $urandom_range(0, 4);
      plan_user(r, d, n, 2);
      request_user(r, d);
      wait_idle(2000, "user");
      check_val("user_init_sticky", int'(init_done), 1);
    end

    // Simultaneous start_init and av_req: init first, user after.
    r = $urandom_range(0, 127);
    d = $urandom_range(0, 511);
    foreach (nk[i]) nk[i] = 0;
    plan_init(nk, 2, ok);
    plan_user(r, d, 0, 1);
    request_user(r, d);
    pulse_start();
    wait_idle(4000, "init_user");
    check_val("init_user_done", int'(init_done), 1);

    // start_init during a user transfer is held until it completes.
    r = $urandom_range(0, 127);
    d = $urandom_range(0, 511);
    plan_user(r, d, 0, 2);
    plan_init(nk, 1, ok);
    base = n_go;
    request_user(r, d);
    wait_go(base + 1, 100, "pend_go");
    start_init = 1'b1;
    @(negedge clk);
    start_init = 1'b0;
    wait_idle(4000, "pend_init");
    check_val("pend_init_done", int'(init_done), 1);

    // Reset while waiting on the third init word.
    plan_init(nk, 2, ok);
    base = n_go;
    pulse_start();
    wait_go(base + 3, 1000, "rst_go");
    @(negedge clk);
    check_val("rst_mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    n_flushed += exp_q.size();
    exp_q.delete();
    nack_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    base = n_go;
    repeat (60) @(negedge clk);
    check_val("rst_no_go", n_go, base);
    check_val("rst_idle", int'(busy), 0);

    check_val("go_count", n_go, n_pushed - n_flushed);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
